// File: rtl/stop_watch_uart_pkg.sv
// Shared constants and state encoding for the stopwatch UART report path.
// The frame layout is fixed at six bytes: D2 D1 '.' D0 CR LF.
package stop_watch_uart_pkg;

    localparam int FRAME_LEN = 6;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/stop_watch_uart_reporter_bcd_to_ascii.sv
// Combinational BCD digit to ASCII character converter.
// Non-decimal codes (10..15) render as '?' so corrupt digits stay visible on the terminal.
module bcd_to_ascii
    import stop_watch_uart_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (bcd_i <= 4'd9) begin
            ascii_o = ASCII_ZERO + {4'h0, bcd_i};
        end else begin
            ascii_o = ASCII_QMARK;
        end
    end

endmodule

// File: rtl/stop_watch_uart_reporter.sv
// Snapshots the stopwatch digits on request and streams "D2 D1 . D0 CR LF" into the UART TX FIFO.
// Optional macro STOPWATCH_AUTO_REPORT_EN adds a periodic internal report request.
module stop_watch_uart_reporter
    import stop_watch_uart_pkg::*;
`ifdef STOPWATCH_AUTO_REPORT_EN
#(
    parameter int REPORT_PERIOD = 50_000_000
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       send_tick,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       req_dropped
);

    localparam int IW = $clog2(FRAME_LEN);

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic [11:0]     snap_q;
    logic            req_dropped_q;
    logic            req;
    logic            last_byte;
    logic [3:0]      digit;
    logic [7:0]      digit_ascii;
    logic [7:0]      frame_byte;

`ifdef STOPWATCH_AUTO_REPORT_EN
    localparam int CW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;

    logic [CW-1:0] period_cnt_q;
    logic          auto_req;

    assign auto_req = (period_cnt_q == CW'(REPORT_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else if (auto_req) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_q + CW'(1);
        end
    end

    assign req = send_tick | auto_req;
`else
    assign req = send_tick;
`endif

    // One shared converter: only the digit addressed by the current index is needed.
    always_comb begin
        case (idx_q)
            IW'(0):  digit = snap_q[11:8];
            IW'(1):  digit = snap_q[7:4];
            default: digit = snap_q[3:0];
        endcase
    end

    bcd_to_ascii u_bcd_to_ascii (
        .bcd_i   (digit),
        .ascii_o (digit_ascii)
    );

    always_comb begin
        case (idx_q)
            IW'(0), IW'(1), IW'(3): frame_byte = digit_ascii;
            IW'(2):                 frame_byte = ASCII_DOT;
            IW'(4):                 frame_byte = ASCII_CR;
            default:                frame_byte = ASCII_LF;
        endcase
    end

    assign last_byte   = (idx_q == IW'(FRAME_LEN - 1));
    assign idx_d       = idx_q + IW'(1);
    assign wr_uart     = (state_q == SEND) && !tx_full;
    assign w_data      = wr_uart ? frame_byte : 8'h00;
    assign busy        = (state_q == SEND);
    assign req_dropped = req_dropped_q;

    // Requests seen while a frame is in flight, including its final write, are flagged and discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            req_dropped_q <= 1'b0;
        end else begin
            req_dropped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        snap_q  <= {d2, d1, d0};
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    req_dropped_q <= req;
                    if (!tx_full) begin
                        if (last_byte) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stop_watch_uart_reporter.sv
// Self-checking bench for stop_watch_uart_reporter: directed frames plus random traffic
// compared against a byte-queue reference model.
module tb_stop_watch_uart_reporter;

`ifdef STOPWATCH_AUTO_REPORT_EN
    localparam int  PERIOD = 20;
    localparam bit  AUTO   = 1'b1;
`else
    localparam int  PERIOD = 20;
    localparam bit  AUTO   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d2, d1, d0;
    logic       send_tick;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       busy;
    logic       req_dropped;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int cycles;
    logic lastBusy;

    bit         mBusy;
    logic [7:0] mQ[$];
    bit         mDrop;
    int         autoCnt;

`ifdef STOPWATCH_AUTO_REPORT_EN
    stop_watch_uart_reporter #(.REPORT_PERIOD(PERIOD)) dut (
`else
    stop_watch_uart_reporter dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0),
        .send_tick   (send_tick),
        .tx_full     (tx_full),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .busy        (busy),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] asc(input logic [3:0] x);
        if (x <= 4'd9) return 8'h30 + {4'h0, x};
        return 8'h3F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model, take the edge.
    task automatic applyStimulus(input logic tick, input logic full);
        logic expWr;
        logic req;
        bit   wasBusy;
        send_tick = tick;
        tx_full   = full;
        @(negedge clk);
        expWr = mBusy && !full;
        checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
        checkOutput("wr_uart", {31'b0, wr_uart}, {31'b0, expWr});
        checkOutput("req_dropped", {31'b0, req_dropped}, {31'b0, mDrop});
        if (expWr && mQ.size() > 0) checkOutput("w_data", {24'b0, w_data}, {24'b0, mQ[0]});
        lastBusy = busy;
        if (wr_uart === 1'b1) writes++;
        req     = tick || (AUTO && autoCnt == PERIOD - 1);
        wasBusy = mBusy;
        if (wasBusy && !full) begin
            void'(mQ.pop_front());
            if (mQ.size() == 0) mBusy = 1'b0;
        end
        if (!wasBusy && req) begin
            mQ    = '{asc(d2), asc(d1), 8'h2E, asc(d0), 8'h0D, 8'h0A};
            mBusy = 1'b1;
        end
        mDrop   = wasBusy && req;
        autoCnt = (autoCnt == PERIOD - 1) ? 0 : autoCnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        send_tick = 1'b0;
        tx_full   = 1'b0;
        #2;
        checkOutput("rst_wr_uart", {31'b0, wr_uart}, 32'd0);
        checkOutput("rst_w_data", {24'b0, w_data}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_req_dropped", {31'b0, req_dropped}, 32'd0);
        mBusy   = 1'b0;
        mQ.delete();
        mDrop   = 1'b0;
        autoCnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Tick once, then run until busy falls; digits jump to 9,9,9 mid-frame.
    task automatic runFrame(input int stallAt, input int dropAt, output int busyCycles);
        int k;
        writes = 0;
        applyStimulus(1'b1, 1'b0);
        d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
        k = 0;
        do begin
            applyStimulus(k == dropAt, (stallAt >= 0) && (k >= stallAt) && (k < stallAt + 3));
            k++;
        end while (lastBusy === 1'b1 && k < 40);
        busyCycles = k - 1;
    endtask

    initial begin
        d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
        doReset();

        d2 = 4'd1; d1 = 4'd2; d0 = 4'd7;
        runFrame(-1, -1, cycles);
        checkOutput("plain_busy_cycles", cycles, 32'd6);
        checkOutput("plain_writes", writes, 32'd6);

        d2 = 4'd1; d1 = 4'd2; d0 = 4'd7;
        runFrame(2, -1, cycles);
        checkOutput("stall_busy_cycles", cycles, 32'd9);
        checkOutput("stall_writes", writes, 32'd6);

        d2 = 4'd1; d1 = 4'd2; d0 = 4'd7;
        runFrame(-1, 1, cycles);
        checkOutput("drop_busy_cycles", cycles, 32'd6);
        checkOutput("drop_writes", writes, 32'd6);

        d2 = 4'd1; d1 = 4'd2; d0 = 4'd7;
        runFrame(-1, 5, cycles);
        checkOutput("droplast_writes", writes, 32'd6);
        applyStimulus(1'b0, 1'b0);

        d2 = 4'd3; d1 = 4'hC; d0 = 4'd0;
        runFrame(-1, -1, cycles);
        checkOutput("qmark_writes", writes, 32'd6);

        d2 = 4'd1; d1 = 4'd2; d0 = 4'd7;
        writes = 0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        doReset();
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_writes", writes, 32'd2);

        d2 = 4'd5; d1 = 4'd8; d0 = 4'd4;
        runFrame(-1, -1, cycles);
        checkOutput("after_abort_writes", writes, 32'd6);

        for (int i = 0; i < 400; i++) begin
            d2 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
